// File: rtl/data_memory_pkg.sv
// Shared definitions for the data_memory block.
// Holds the access-size codes used by both the read and write lanes
// of each port, and a helper that maps a size code to its byte count.
package data_memory_pkg;

  localparam logic [1:0] SIZE_NONE = 2'd0;
  localparam logic [1:0] SIZE_BYTE = 2'd1;
  localparam logic [1:0] SIZE_HALF = 2'd2;
  localparam logic [1:0] SIZE_WORD = 2'd3;

  // Number of bytes touched by an access of the given size code (0, 1, 2 or 4).
  function automatic logic [2:0] size_bytes(input logic [1:0] code);
    case (code)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      SIZE_WORD: size_bytes = 3'd4;
      default:   size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Bus bundle for data_memory.
// Carries both the system-side port (MemWriteBus/MemAddrBus/WDMB/RDMB ->
// MemReadBus) and the client port (ClientMemWrite/ClientMemAddr/CWDM/CRDM ->
// ClientMemRead).
//   master : the requesters (datapath and client), drive address/data/sizes
//   slave  : the memory, returns both read words
interface data_memory_if;

  logic [31:0] MemWriteBus;
  logic [31:0] MemAddrBus;
  logic [1:0]  WDMB;
  logic [1:0]  RDMB;
  logic [31:0] ClientMemWrite;
  logic [31:0] ClientMemAddr;
  logic [1:0]  CWDM;
  logic [1:0]  CRDM;
  logic [31:0] MemReadBus;
  logic [31:0] ClientMemRead;

  modport master (
    output MemWriteBus, MemAddrBus, WDMB, RDMB,
    output ClientMemWrite, ClientMemAddr, CWDM, CRDM,
    input  MemReadBus, ClientMemRead
  );

  modport slave (
    input  MemWriteBus, MemAddrBus, WDMB, RDMB,
    input  ClientMemWrite, ClientMemAddr, CWDM, CRDM,
    output MemReadBus, ClientMemRead
  );

endinterface

// File: rtl/data_memory_read_port.sv
// Combinational little-endian read lane.
// Ports:
//   mem_i  : full byte-array view
//   addr_i : decoded byte address (ADDR_BITS wide)
//   size_i : read-size code
//   data_o : bytes addr..addr+n-1 in [8n-1:0], upper bits zero
// Byte addresses wrap modulo the array depth.
module data_memory_read_port
  import data_memory_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic [7:0]           mem_i [2**ADDR_BITS],
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [1:0]           size_i,
  output logic [31:0]          data_o
);

  logic [2:0]           n_bytes;
  logic [ADDR_BITS-1:0] byte_addr;

  always_comb begin
    data_o    = 32'h0;
    byte_addr = addr_i;
    n_bytes   = size_bytes(size_i);
    for (int k = 0; k < 4; k++) begin
      // Natural truncation of the sum gives the wrap to address 0.
      byte_addr = addr_i + ADDR_BITS'(k);
      if (3'(k) < n_bytes) begin
        data_o[8*k +: 8] = mem_i[byte_addr];
      end
    end
  end

endmodule

// File: rtl/data_memory.sv
// Dual-port byte-addressable data memory.
// Ports:
//   Clk : write clock, writes commit on the rising edge
//   Rst : asynchronous active-high reset, clears the whole array
//   bus : data_memory_if.slave, system port and client port
// Reads are combinational on both ports. Writes are little-endian, 1/2/4
// bytes, with wrap modulo 2^ADDR_BITS. When both ports write the same byte
// in one cycle the system port wins.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  data_memory_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_BITS;

  logic [7:0] mem_q [DEPTH];

  // Per-byte write lanes: enable, target address and data for each of the
  // four possible bytes of an access.
  logic [3:0]           sys_en_d;
  logic [3:0]           cli_en_d;
  logic [ADDR_BITS-1:0] sys_addr_d [4];
  logic [ADDR_BITS-1:0] cli_addr_d [4];
  logic [7:0]           sys_byte_d [4];
  logic [7:0]           cli_byte_d [4];
  logic [2:0]           sys_n;
  logic [2:0]           cli_n;

  always_comb begin
    sys_n = size_bytes(bus.WDMB);
    cli_n = size_bytes(bus.CWDM);
    for (int k = 0; k < 4; k++) begin
      sys_en_d[k]   = (3'(k) < sys_n);
      cli_en_d[k]   = (3'(k) < cli_n);
      sys_addr_d[k] = bus.MemAddrBus[ADDR_BITS-1:0] + ADDR_BITS'(k);
      cli_addr_d[k] = bus.ClientMemAddr[ADDR_BITS-1:0] + ADDR_BITS'(k);
      sys_byte_d[k] = bus.MemWriteBus[8*k +: 8];
      cli_byte_d[k] = bus.ClientMemWrite[8*k +: 8];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mem_q <= '{default: 8'h00};
    end else begin
      // Client lane first; the system lane is issued afterwards so its
      // non-blocking update takes precedence on any shared byte.
      for (int k = 0; k < 4; k++) begin
        if (cli_en_d[k]) mem_q[cli_addr_d[k]] <= cli_byte_d[k];
      end
      for (int k = 0; k < 4; k++) begin
        if (sys_en_d[k]) mem_q[sys_addr_d[k]] <= sys_byte_d[k];
      end
    end
  end

  data_memory_read_port #(.ADDR_BITS(ADDR_BITS)) u_sys_rd (
    .mem_i  (mem_q),
    .addr_i (bus.MemAddrBus[ADDR_BITS-1:0]),
    .size_i (bus.RDMB),
    .data_o (bus.MemReadBus)
  );

  data_memory_read_port #(.ADDR_BITS(ADDR_BITS)) u_cli_rd (
    .mem_i  (mem_q),
    .addr_i (bus.ClientMemAddr[ADDR_BITS-1:0]),
    .size_i (bus.CRDM),
    .data_o (bus.ClientMemRead)
  );

  // Address bits above ADDR_BITS are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.MemAddrBus[31:ADDR_BITS], bus.ClientMemAddr[31:ADDR_BITS]};

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  data_memory_if bus ();

  data_memory #(.ADDR_BITS(16)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.WDMB = 2'd0;
    bus.CWDM = 2'd0;
    bus.RDMB = 2'd0;
    bus.CRDM = 2'd0;
  endtask

  task automatic cli_rd(input logic [31:0] a, input logic [1:0] s);
    bus.ClientMemAddr = a;
    bus.CRDM          = s;
    #1;
  endtask

  task automatic sys_rd(input logic [31:0] a, input logic [1:0] s);
    bus.MemAddrBus = a;
    bus.RDMB       = s;
    #1;
  endtask

  logic [31:0] exp_bytes [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.MemWriteBus    = '0;
    bus.MemAddrBus     = '0;
    bus.ClientMemWrite = '0;
    bus.ClientMemAddr  = '0;
    idle();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    cli_rd(32'h8000, 2'd3);
    check("reset_word", bus.ClientMemRead, 32'h0);

    // System word write, client byte reads
    bus.MemAddrBus  = 32'h8000;
    bus.MemWriteBus = 32'h44332211;
    bus.WDMB        = 2'd3;
    tick();
    idle();
    exp_bytes = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      cli_rd(32'h8000 + i, 2'd1);
      check($sformatf("byte_rd_%0d", i), bus.ClientMemRead, exp_bytes[i]);
    end
    cli_rd(32'h8001, 2'd2);
    check("half_rd_8001", bus.ClientMemRead, 32'h3322);
    sys_rd(32'h8000, 2'd0);
    check("size0_rd", bus.MemReadBus, 32'h0);

    // Partial write preserves neighbours
    bus.ClientMemAddr  = 32'h8002;
    bus.ClientMemWrite = 32'h123456AA;
    bus.CWDM           = 2'd1;
    tick();
    idle();
    sys_rd(32'h8000, 2'd3);
    check("partial_wr", bus.MemReadBus, 32'h44AA2211);

    // Collision: system wins
    bus.MemAddrBus     = 32'h9000;
    bus.MemWriteBus    = 32'h1;
    bus.WDMB           = 2'd3;
    bus.ClientMemAddr  = 32'h9000;
    bus.ClientMemWrite = 32'h2;
    bus.CWDM           = 2'd3;
    tick();
    idle();
    sys_rd(32'h9000, 2'd3);
    check("collide_word", bus.MemReadBus, 32'h1);

    // Non-overlapping simultaneous writes both commit
    bus.MemAddrBus     = 32'h9000;
    bus.MemWriteBus    = 32'hFFFFFF77;
    bus.WDMB           = 2'd1;
    bus.ClientMemAddr  = 32'h9004;
    bus.ClientMemWrite = 32'h5555BEEF;
    bus.CWDM           = 2'd2;
    tick();
    idle();
    sys_rd(32'h9000, 2'd3);
    check("dual_sys_byte", bus.MemReadBus, 32'h77);
    cli_rd(32'h9004, 2'd3);
    check("dual_cli_half", bus.ClientMemRead, 32'hBEEF);

    // Wrap-around at top of memory
    bus.MemAddrBus  = 32'hFFFE;
    bus.MemWriteBus = 32'hDDCCBBAA;
    bus.WDMB        = 2'd3;
    tick();
    idle();
    cli_rd(32'hFFFE, 2'd1);
    check("wrap_fffe", bus.ClientMemRead, 32'hAA);
    cli_rd(32'hFFFF, 2'd1);
    check("wrap_ffff", bus.ClientMemRead, 32'hBB);
    cli_rd(32'h0000, 2'd1);
    check("wrap_0000", bus.ClientMemRead, 32'hCC);
    cli_rd(32'h0001, 2'd1);
    check("wrap_0001", bus.ClientMemRead, 32'hDD);
    sys_rd(32'hFFFE, 2'd3);
    check("wrap_word", bus.MemReadBus, 32'hDDCCBBAA);
    cli_rd(32'h0001_8000, 2'd3);
    check("alias_18000", bus.ClientMemRead, 32'h44AA2211);

    // Read-during-write
    bus.MemAddrBus  = 32'hA000;
    bus.MemWriteBus = 32'h12345678;
    bus.WDMB        = 2'd3;
    cli_rd(32'hA000, 2'd3);
    check("rdw_old", bus.ClientMemRead, 32'h0);
    tick();
    bus.WDMB = 2'd0;
    #1;
    check("rdw_new", bus.ClientMemRead, 32'h12345678);

    // Asynchronous reset mid-sequence
    cli_rd(32'h8000, 2'd3);
    sys_rd(32'hFFFE, 2'd3);
    rst = 1'b1;
    #1;
    check("arst_cli", bus.ClientMemRead, 32'h0);
    check("arst_sys", bus.MemReadBus, 32'h0);

    // Write during reset is dropped
    bus.MemAddrBus  = 32'hB000;
    bus.MemWriteBus = 32'hCAFEF00D;
    bus.WDMB        = 2'd3;
    tick();
    rst = 1'b0;
    bus.WDMB = 2'd0;
    #1;
    sys_rd(32'hB000, 2'd3);
    check("rst_wr_drop", bus.MemReadBus, 32'h0);

    // Writes work again after reset
    bus.ClientMemAddr  = 32'hB000;
    bus.ClientMemWrite = 32'hCAFEF00D;
    bus.CWDM           = 2'd3;
    tick();
    idle();
    sys_rd(32'hB000, 2'd2);
    check("post_rst_half", bus.MemReadBus, 32'hF00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Dual-port, byte-addressable data memory shared by the system-side datapath (variable manager / interpreter) and an external client port such as a debugger or test host. Each port has its own address, write data, write-size code and read-size code. Writes are synchronous and little-endian; reads are combinational. The asynchronous reset clears the whole array.

## Interface
- ADDR_BITS, default 16: number of byte-address bits actually decoded; depth = 2^ADDR_BITS bytes.
- Clk  input  1: single clock; writes commit on the rising edge.
- Rst  input  1: asynchronous, active-high reset.
- MemWriteBus  input  32: system-port write data; byte 0 is bits [7:0].
- MemAddrBus  input  32: system-port byte address.
- WDMB  input  2: system-port write-size code.
- RDMB  input  2: system-port read-size code.
- ClientMemWrite  input  32: client-port write data.
- ClientMemAddr  input  32: client-port byte address.
- CWDM  input  2: client-port write-size code.
- CRDM  input  2: client-port read-size code.
- MemReadBus  output  32: system-port read data.
- ClientMemRead  output  32: client-port read data.

## Operation
- Size codes, shared by read and write: 0 = none, 1 = byte (8 bits), 2 = halfword (16 bits), 3 = word (32 bits).
- Address decode: only the low ADDR_BITS bits of an address are used; upper bits are ignored.
- Multi-byte accesses are little-endian: byte k of the access goes to address (A + k) mod 2^ADDR_BITS, so an access that runs past the top of memory wraps to address 0.
- Write, size code s > 0: on the rising edge, store the low 1, 2 or 4 bytes of the write data at A..A+n-1. Bytes outside the access are unchanged.
- Read, size code s > 0: output the bytes at A..A+n-1 in bits [8n-1:0], with the upper bits zero-extended.
- Read, size code 0: output 32'h0.
- Both ports are fully independent. A read and a write may occur on the same port in the same cycle.
- Simultaneous writes to the same byte from both ports: the system port (WDMB) wins. Non-overlapping bytes from both ports are all written.
- Reset: while Rst is high, every byte is 0 and writes are ignored.

## Timing
- Read latency is zero: read outputs are purely combinational from address, size code and array contents.
- Read-during-write on the same byte: the read output shows the old value until the rising edge, and the new value immediately after it.
- Write latency is one edge: data is visible on either port's read output right after the edge that commits it.
- Reset is asynchronous. On assertion the array clears immediately, so both read outputs become 0 regardless of size code.
- Deasserting Rst does not abort anything, because there is no multi-cycle state. An edge coincident with reset deassertion performs no write.
- There is no handshake and no busy signal: every access completes in one cycle.

## Structure
- Shared package holds:
  - the size-code constants SIZE_NONE=2'd0, SIZE_BYTE=2'd1, SIZE_HALF=2'd2, SIZE_WORD=2'd3;
  - a function returning the byte count for a code (0, 1, 2, 4).
- Storage is one byte array of depth 2^ADDR_BITS, with two write lanes resolved per byte with system priority.
- Natural sub-module: data_memory_read_port, instantiated twice. It takes the array view, address and size code, and produces the zero-extended read word. Lane selection reuses the codebase's 8-bit 2:1 multiplexer primitive where convenient.

## Test plan
- Reset then read: after Rst, client reads word at 32'h8000 → 32'h0. Any read with code 0 → 32'h0.
- Word write / byte read: system writes 32'h44332211 at 32'h8000 (WDMB=3). Client reads bytes 32'h8000..32'h8003 (CRDM=1) → 32'h11, 32'h22, 32'h33, 32'h44. Halfword read at 32'h8001 → 32'h3322.
- Partial write preserves neighbours: following the previous step, client writes byte 32'hAA at 32'h8002 (CWDM=1). System reads word at 32'h8000 → 32'h44AA2211.
- Write collision: both ports write a word at 32'h9000 in the same cycle (system 32'h1, client 32'h2) → word reads 32'h1. Client halfword 32'hBEEF at 32'h9004 in the same cycle as a system byte write 32'h77 at 32'h9000 → both commit.
- Wrap-around: word write 32'hDDCCBBAA at address 32'hFFFE (ADDR_BITS=16) → bytes 32'hFFFE=AA, 32'hFFFF=BB, 32'h0000=CC, 32'h0001=DD. Address 32'h1_8000 aliases to 32'h8000.
- Read-during-write and reset: the read output shows the old value before the edge and the new value after it. Asserting Rst mid-sequence zeroes all reads immediately, and a write presented during reset is dropped.
